// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between an I-cache and a D-cache.
//
// A D-side request wins over an I-side request when both are pending in IDLE.
// A D write-through takes one WRITE cycle. A block fill (I miss or D read
// miss) issues 8 consecutive word reads and forwards each returned word into
// the owning cache array. Every transaction ends with one DONE cycle that
// pulses the owner's done strobe.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   i_req, i_addr                I-cache miss request and byte address
//   d_req, d_write, d_addr,      D-cache request: write-through (d_write=1)
//   d_wdata                        or block fill (d_write=0)
//   mem_en, mem_wr, mem_addr,    main-memory request port
//   mem_wdata
//   mem_rdata, mem_rvalid        main-memory read return, in issue order
//   fill_we, fill_sel,           word write into the selected cache array
//   fill_word, fill_data           (fill_sel: 0 = I-cache, 1 = D-cache)
//   i_done, d_done               one-cycle completion pulses
//   busy                         high whenever the FSM is not idle
module mem_arbiter #(
  parameter int unsigned WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        fill_we,
  output logic        fill_sel,
  output logic [2:0]  fill_word,
  output logic [15:0] fill_data,
  output logic        i_done,
  output logic        d_done,
  output logic        busy
);

  // Counters run 0..WORDS, so they need one bit more than a word index.
  localparam int unsigned CntW = 4;
  localparam logic [CntW-1:0] NumWords = CntW'(WORDS);
  localparam logic [CntW-1:0] LastWord = CntW'(WORDS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StFill,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;   // 0 = I-cache, 1 = D-cache
  logic            write_q, write_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [15:0]     addr_q, addr_d;     // unmasked; block base is addr_q[15:4]
  logic [CntW-1:0] issue_q, issue_d;
  logic [CntW-1:0] recv_q, recv_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      write_q <= 1'b0;
      wdata_q <= 16'h0000;
      addr_q  <= 16'h0000;
      issue_q <= '0;
      recv_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      issue_q <= issue_d;
      recv_q  <= recv_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    addr_d    = addr_q;
    issue_d   = issue_q;
    recv_d    = recv_q;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    fill_we   = 1'b0;
    fill_sel  = 1'b0;
    fill_word = 3'd0;
    fill_data = 16'h0000;
    i_done    = 1'b0;
    d_done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (d_req) begin
          owner_d = 1'b1;
          write_d = d_write;
          wdata_d = d_wdata;
          addr_d  = d_addr;
          issue_d = '0;
          recv_d  = '0;
          state_d = d_write ? StWrite : StFill;
        end else if (i_req) begin
          owner_d = 1'b0;
          write_d = 1'b0;
          wdata_d = 16'h0000;
          addr_d  = i_addr;
          issue_d = '0;
          recv_d  = '0;
          state_d = StFill;
        end
      end

      StWrite: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        state_d   = StDone;
      end

      StFill: begin
        if (issue_q < NumWords) begin
          mem_en = 1'b1;
          // Word offset replaces the low nibble, so the address cannot carry
          // out of the block.
          mem_addr = {addr_q[15:4], issue_q[2:0], 1'b0};
          issue_d  = issue_q + 1'b1;
        end
        if (mem_rvalid && (recv_q < NumWords)) begin
          fill_we   = 1'b1;
          fill_sel  = owner_q;
          fill_word = recv_q[2:0];
          fill_data = mem_rdata;
          recv_d    = recv_q + 1'b1;
          if (recv_q == LastWord) begin
            state_d = StDone;
          end
        end
      end

      StDone: begin
        i_done  = ~owner_q;
        d_done  = owner_q;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a fixed-latency memory
// model (read data = address ^ 16'hC3A5) and a negedge event logger.
module tb_mem_arbiter;

  localparam int Lat = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = 16'h0000;
  logic        d_req = 1'b0;
  logic        d_write = 1'b0;
  logic [15:0] d_addr = 16'h0000;
  logic [15:0] d_wdata = 16'h0000;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rvalid;
  logic        fill_we, fill_sel;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        i_done, d_done, busy;

  always #5 clk = ~clk;

  mem_arbiter #(.WORDS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .d_req      (d_req),
    .d_write    (d_write),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .mem_en     (mem_en),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .fill_we    (fill_we),
    .fill_sel   (fill_sel),
    .fill_word  (fill_word),
    .fill_data  (fill_data),
    .i_done     (i_done),
    .d_done     (d_done),
    .busy       (busy)
  );

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  // Memory model: not reset, so reads in flight across a reset still return.
  logic [Lat-1:0] pv = '0;
  logic [15:0]    pa [Lat];
  always @(posedge clk) begin
    pv    <= {pv[Lat-2:0], mem_en & ~mem_wr};
    pa[0] <= mem_addr;
    for (int i = 1; i < Lat; i++) pa[i] <= pa[i-1];
  end
  assign mem_rvalid = pv[Lat-1];
  assign mem_rdata  = pv[Lat-1] ? mem_fn(pa[Lat-1]) : 16'h0000;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event logger.
  logic [15:0] rd_addr [256];
  int          rd_cyc  [256];
  int          rd_n = 0;
  logic [3:0]  fl_tag  [256];
  logic [15:0] fl_data [256];
  int          fl_n = 0;
  logic [15:0] wr_addr_l = 16'h0000, wr_data_l = 16'h0000;
  int          wr_n = 0, wr_cyc = 0;
  int          idone_n = 0, ddone_n = 0, idone_cyc = 0, ddone_cyc = 0;

  always @(negedge clk) begin
    if (mem_en && !mem_wr && rd_n < 256) begin
      rd_addr[rd_n] <= mem_addr;
      rd_cyc[rd_n]  <= cyc;
      rd_n          <= rd_n + 1;
    end
    if (mem_en && mem_wr) begin
      wr_addr_l <= mem_addr;
      wr_data_l <= mem_wdata;
      wr_cyc    <= cyc;
      wr_n      <= wr_n + 1;
    end
    if (fill_we && fl_n < 256) begin
      fl_tag[fl_n]  <= {fill_sel, fill_word};
      fl_data[fl_n] <= fill_data;
      fl_n          <= fl_n + 1;
    end
    if (i_done) begin
      idone_n   <= idone_n + 1;
      idone_cyc <= cyc;
    end
    if (d_done) begin
      ddone_n   <= ddone_n + 1;
      ddone_cyc <= cyc;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] all_outs();
    return {6'd0, mem_en, mem_wr, mem_addr, mem_wdata, fill_we, fill_sel, fill_word,
            fill_data, i_done, d_done, busy};
  endfunction

  // Runs until both requesters are satisfied and the FSM is idle; each
  // requester drops its request on seeing its done pulse.
  task automatic wait_idle(input string tag);
    int n = 0;
    while ((i_req || d_req || busy) && n < 200) begin
      @(negedge clk);
      if (i_done) i_req = 1'b0;
      if (d_done) d_req = 1'b0;
      n++;
    end
    check({tag, " finished"}, 64'(n < 200), 64'd1);
  endtask

  task automatic check_fill(input string tag, input int r0, input int f0,
                            input logic [15:0] base, input logic sel);
    check({tag, " read count"}, 64'(rd_n - r0 >= 8), 64'd1);
    check({tag, " fill count"}, 64'(fl_n - f0 >= 8), 64'd1);
    check({tag, " back-to-back"}, 64'(rd_cyc[r0+7] - rd_cyc[r0]), 64'd7);
    for (int k = 0; k < 8; k++) begin
      logic [15:0] a;
      a = base + 16'(2 * k);
      check($sformatf("%s addr%0d", tag, k), 64'(rd_addr[r0+k]), 64'(a));
      check($sformatf("%s tag%0d", tag, k), 64'(fl_tag[f0+k]), 64'({sel, 3'(k)}));
      check($sformatf("%s data%0d", tag, k), 64'(fl_data[f0+k]), 64'(mem_fn(a)));
    end
  endtask

  initial begin
    int n0, r0, f0, w0, id0, dd0, n;

    // Reset state.
    #1 rst = 1'b1;
    #1 check("reset outputs", all_outs(), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle outputs", all_outs(), 64'd0);

    // I fill from a mid-block address.
    n0 = cyc; r0 = rd_n; f0 = fl_n; id0 = idone_n;
    i_addr = 16'h1236; i_req = 1'b1;
    wait_idle("ifill");
    check_fill("ifill", r0, f0, 16'h1230, 1'b0);
    check("ifill first issue cyc", 64'(rd_cyc[r0] - n0), 64'd1);
    check("ifill done cyc", 64'(idone_cyc - n0), 64'd13);
    check("ifill done pulses", 64'(idone_n - id0), 64'd1);
    @(negedge clk);
    check("ifill busy after", 64'(busy), 64'd0);

    // D write-through.
    n0 = cyc; r0 = rd_n; f0 = fl_n; w0 = wr_n;
    d_addr = 16'h0102; d_wdata = 16'hBEEF; d_write = 1'b1; d_req = 1'b1;
    wait_idle("dwrite");
    d_write = 1'b0;
    check("dwrite count", 64'(wr_n - w0), 64'd1);
    check("dwrite addr", 64'(wr_addr_l), 64'h0102);
    check("dwrite data", 64'(wr_data_l), 64'hBEEF);
    check("dwrite cyc", 64'(wr_cyc - n0), 64'd1);
    check("dwrite done cyc", 64'(ddone_cyc - n0), 64'd2);
    check("dwrite no fills", 64'(fl_n - f0), 64'd0);
    check("dwrite no reads", 64'(rd_n - r0), 64'd0);

    // Simultaneous requests: D first, then I.
    r0 = rd_n; f0 = fl_n;
    i_addr = 16'h2000; d_addr = 16'h4000; i_req = 1'b1; d_req = 1'b1;
    wait_idle("both");
    check_fill("both d", r0, f0, 16'h4000, 1'b1);
    check_fill("both i", r0 + 8, f0 + 8, 16'h2000, 1'b0);
    check("both i start cyc", 64'(rd_cyc[r0+8] - ddone_cyc), 64'd2);

    // d_req arriving mid I fill must wait.
    r0 = rd_n; f0 = fl_n;
    i_addr = 16'h3000; i_req = 1'b1;
    n = 0;
    while (fl_n - f0 < 3 && n < 60) begin
      @(negedge clk);
      n++;
    end
    d_addr = 16'h5010; d_req = 1'b1;
    wait_idle("nopreempt");
    check_fill("nopreempt i", r0, f0, 16'h3000, 1'b0);
    check_fill("nopreempt d", r0 + 8, f0 + 8, 16'h5010, 1'b1);
    check("nopreempt order", 64'(idone_cyc < ddone_cyc), 64'd1);

    // Reset in the middle of a fill.
    r0 = rd_n;
    i_addr = 16'h7000; i_req = 1'b1;
    n = 0;
    while (rd_n - r0 < 5 && n < 60) begin
      @(negedge clk);
      n++;
    end
    #2 rst = 1'b1;
    i_req = 1'b0;
    #1 check("midfill reset outputs", all_outs(), 64'd0);
    f0 = fl_n;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    r0 = rd_n;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_rvalid) check("stale rvalid fill_we", 64'(fill_we), 64'd0);
    end
    check("after reset fills", 64'(fl_n - f0), 64'd0);
    check("after reset reads", 64'(rd_n - r0), 64'd0);
    r0 = rd_n; f0 = fl_n;
    i_addr = 16'h7000; i_req = 1'b1;
    wait_idle("postreset");
    check_fill("postreset", r0, f0, 16'h7000, 1'b0);

    // Top-of-memory block; address input changes mid-fill are ignored.
    r0 = rd_n; f0 = fl_n;
    i_addr = 16'hFFFA; i_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    i_addr = 16'h0000;
    wait_idle("top");
    check_fill("top", r0, f0, 16'hFFF0, 1'b0);
    check("top read count exact", 64'(rd_n - r0), 64'd8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORDS, default 8: words per cache block; fixed at 8, 16-bit words, block 16 bytes.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 i_req  in  1  I-cache read miss; held high until i_done.
REQ-005 i_addr  in  16  I-cache miss byte address.
REQ-006 d_req  in  1  D-cache access request (read miss or write-through); held high until d_done.
REQ-007 d_write  in  1  with d_req: 1 = single-word write-through, 0 = block fill.
REQ-008 d_addr  in  16  D-side byte address.
REQ-009 d_wdata  in  16  D-side write data.
REQ-010 mem_en  out  1  main-memory access strobe.
REQ-011 mem_wr  out  1  main-memory write enable, valid with mem_en.
REQ-012 mem_addr  out  16  main-memory byte address.
REQ-013 mem_wdata  out  16  main-memory write data.
REQ-014 mem_rdata  in  16  main-memory read data.
REQ-015 mem_rvalid  in  1  mem_rdata valid; one pulse per read, in issue order, fixed latency.
REQ-016 fill_we  out  1  write one word into selected cache array.
REQ-017 fill_sel  out  1  0 = I-cache, 1 = D-cache.
REQ-018 fill_word  out  3  word index within block.
REQ-019 fill_data  out  16  word to write.
REQ-020 i_done, d_done  out  1 each  one-cycle completion pulse to owning requester.
REQ-021 busy  out  1  high in every state except IDLE.

Function
REQ-022 FSM states SHALL be IDLE, WRITE, FILL, DONE.
REQ-023 IDLE: d_req has priority over i_req; no request -> stay IDLE, all strobes 0.
REQ-024 Grant SHALL latch owner, d_write, d_wdata, and base = addr & 16'hFFF0; later input changes ignored until IDLE.
REQ-025 Grant to D with d_write=1 -> WRITE: one cycle, mem_en=1, mem_wr=1, mem_addr=d_addr latched unmasked, mem_wdata=latched d_wdata; then DONE.
REQ-026 Grant to D (d_write=0) or I -> FILL; issue counter and receive counter cleared to 0.
REQ-027 FILL issue: while issue count < 8, mem_en=1, mem_wr=0, mem_addr=base + 2*count, count increments; 8 consecutive cycles, first in the cycle after grant.
REQ-028 FILL receive: each mem_rvalid -> same cycle fill_we=1, fill_sel=owner, fill_word=receive count[2:0], fill_data=mem_rdata; receive count increments.
REQ-029 Issue and receive overlap; mem_rvalid in the same cycle as an issue is accepted.
REQ-030 When the 8th word is received -> DONE next cycle; block address never exceeds base+14 (no wrap).
REQ-031 DONE: exactly one cycle; pulse i_done or d_done per owner; requests ignored; then IDLE.
REQ-032 Requester SHALL drop its req in the cycle after done; a req still high in IDLE is a new request.
REQ-033 An I fill in progress SHALL NOT be preempted by d_req; D waits, granted in IDLE after DONE.
REQ-034 mem_rvalid outside FILL, or after 8 words received, SHALL be ignored (no fill_we).
REQ-035 mem_wr SHALL be 0 whenever mem_en is 0; mem_addr/mem_wdata are don't-care then but driven 0 in IDLE.

Reset
REQ-036 rst high, at any time including mid-FILL or WRITE: state IDLE, counters 0, latches 0, every output 0, immediately (asynchronously).
REQ-037 After rst release, rvalid pulses from pre-reset reads SHALL be ignored (REQ-034).

Verification
REQ-038 i_req=1, i_addr=0x1236, memory latency 4 -> mem_addr 0x1230..0x123E over 8 cycles; 8 fill_we with fill_sel=0, fill_word 0..7; i_done one pulse; busy 0 after.
REQ-039 i_req and d_req (d_write=0, d_addr=0x4000) both high in IDLE -> D fills 0x4000..0x400E first, d_done, then I fill begins the cycle after returning to IDLE.
REQ-040 d_req=1, d_write=1, d_addr=0x0102, d_wdata=0xBEEF -> one cycle mem_en=1, mem_wr=1, mem_addr=0x0102, mem_wdata=0xBEEF; d_done two cycles after grant; no fill_we.
REQ-041 During I fill at word 3, assert d_req -> I fill completes all 8 words, i_done, then D granted.
REQ-042 Assert rst after 5 issues of a fill -> all outputs 0 at once; remaining rvalid pulses produce no fill_we; new i_req after release fills normally.
REQ-043 i_addr=0xFFFA -> addresses 0xFFF0..0xFFFE, no wrap to 0x0000.
